branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  EX-stage branch resolution with dynamic prediction for the RV32I pipeline. Parametrised in
//  XLEN and predictor depth.
//  Evaluates all six RV32I branch conditions and owns a table of 2-bit saturating counters (BHT).
//  The IF stage reads the BHT combinationally for pred_taken. EX resolves the branch, trains the
//  BHT, and raises a registered one-cycle redirect on misprediction.
// PARAMETERS
//  XLEN       32   operand/PC width
//  BHT_DEPTH  64   counter entries, power of 2, >=2; index = pc[$clog2(BHT_DEPTH)+1:2]
//  CNT_W      32   width of the statistics counters (only with BRANCH_STATS_EN)
// PORTS
//  clk            in   1          sole clock, rising edge
//  rst            in   1          synchronous reset, active-high
//  if_pc          in   XLEN       fetch PC used for prediction lookup
//  if_pred_taken  out  1          comb: MSB of BHT[idx(if_pc)]
//  ex_valid       in   1          EX slot holds a live instruction
//  ex_is_branch   in   1          instruction is a conditional branch
//  ex_fun3        in   3          funct3 of the branch
//  ex_op_a        in   XLEN       rs1 value
//  ex_op_b        in   XLEN       rs2 value
//  ex_pc          in   XLEN       PC of the branch
//  ex_target      in   XLEN       precomputed pc+imm
//  ex_pred_taken  in   1          prediction carried down the pipe with the branch
//  stall          in   1          pipeline hold; EX input not consumed this cycle
//  flush          in   1          kill EX slot this cycle
//  redirect_valid out  1          reg: one-cycle pulse, mispredict detected
//  redirect_pc    out  XLEN       reg: correct next PC, meaningful while redirect_valid=1
//  br_taken       out  1          reg: actual outcome of the last accepted branch
//  br_illegal     out  1          reg: one-cycle pulse, accepted branch had funct3 010/011
//  stat_branches  out  CNT_W      count of resolved branches (0 when macro off)
//  stat_mispred   out  CNT_W      count of mispredicts (0 when macro off)
// BEHAVIOUR
//  - accept = ex_valid & ex_is_branch & ~stall & ~flush.
//    Flush dominates stall. Nothing is updated unless accept=1.
//  - Condition (comb): 000 beq ==; 001 bne !=; 100 blt signed <; 101 bge signed >=;
//    110 bltu unsigned <; 111 bgeu unsigned >=. Comparisons are full XLEN wide.
//  - funct3 010/011: taken=0. br_illegal pulses next cycle. BHT is not updated.
//    Counted as resolved; not counted as mispredict.
//  - mispredict = accept & legal & (taken != ex_pred_taken).
//  - Latency 1: outputs register at the edge after accept.
//    redirect_pc = taken ? ex_target : ex_pc+4. The +4 wraps modulo 2^XLEN.
//  - redirect_valid and br_illegal are single-cycle pulses: cleared every cycle without a fresh
//    accept. redirect_pc and br_taken hold their value until the next accept.
//  - BHT training on legal accept: idx = idx(ex_pc).
//    taken: cnt = (cnt==3) ? 3 : cnt+1. not taken: cnt = (cnt==0) ? 0 : cnt-1.
//  - Same-cycle read/write of one index: if_pred_taken returns the pre-update value (no bypass).
//  - Reset: all outputs 0, every BHT entry 2'b01 (weakly not-taken), stats 0.
//    Completes in one cycle. rst during an accept discards it.
// CONFIGURATION
//  - BRANCH_STATS_EN defined: stat_branches increments on every accept, stat_mispred on every
//    mispredict. Both saturate at all-ones.
//  - BRANCH_STATS_EN undefined: no counter flops; both stat ports are tied to 0.
// STRUCTURE
//  - branch_pkg: typedef enum logic [2:0] br_fun3_e (BEQ,BNE,BLT,BGE,BLTU,BGEU);
//    typedef logic [1:0] bht_cnt_t; localparams BHT_RESET=2'b01, BHT_MAX=2'b11.
//  - Sub-module branch_bht: counter array with comb read port, sync update port and reset.
//    Parametrised by BHT_DEPTH.
//  - Top module: compare logic, mispredict detection, output registers, optional stats.
// TESTING
//  1. Reset, then beq with a=b=5, pred=0 -> next cycle redirect_valid=1,
//     redirect_pc=ex_target, br_taken=1; redirect_valid=0 one cycle later.
//  2. blt a=32'hFFFF_FFFF, b=1 -> taken. bltu same operands -> not taken.
//     bltu with pred=1, pc=32'h100 -> redirect_pc=32'h104.
//  3. Train pc=32'h40 taken x4 -> BHT saturates at 3 (if_pred_taken=1).
//     Then 1 not-taken -> still predicts taken; a 2nd not-taken -> predicts not taken.
//  4. Accept with stall=1, then with flush=1, then with stall=flush=1 -> no redirect,
//     BHT unchanged, stats unchanged.
//  5. funct3=3'b010 -> br_illegal one-cycle pulse, br_taken=0, no redirect, BHT unchanged.
//  6. BRANCH_STATS_EN, CNT_W=4: 20 mispredicting branches -> stat_mispred=15 (saturated),
//     stat_branches=15. rst -> both 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and counter helpers for the branch resolve unit and its BHT.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_fun3_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_RESET = 2'b01;
    localparam bht_cnt_t BHT_MAX   = 2'b11;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == BHT_MAX) ? BHT_MAX : bht_cnt_t'(cnt + 2'd1);
        end
        return (cnt == 2'b00) ? 2'b00 : bht_cnt_t'(cnt - 2'd1);
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, comb read by fetch PC,
// synchronous training by the resolving branch PC.
module branch_bht
    import branch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_rd_pc,
    output bht_cnt_t        o_rd_cnt,
    input  logic            i_wr_en,
    input  logic [XLEN-1:0] i_wr_pc,
    input  logic            i_wr_taken
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    bht_cnt_t         r_cnt [BHT_DEPTH];
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_unused;

    assign w_rd_idx = i_rd_pc[IDX_W+1:2];
    assign w_wr_idx = i_wr_pc[IDX_W+1:2];
    assign o_rd_cnt = r_cnt[w_rd_idx];

    // Byte offset and upper PC bits do not participate in indexing.
    assign w_unused = ^{i_rd_pc[1:0], i_rd_pc[XLEN-1:IDX_W+2],
                        i_wr_pc[1:0], i_wr_pc[XLEN-1:IDX_W+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                r_cnt[i] <= BHT_RESET;
            end
        end else if (i_wr_en) begin
            r_cnt[w_wr_idx] <= bht_next(r_cnt[w_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with BHT prediction and one-cycle redirect.
// Optional statistics counters enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_fun3,
    input  logic [XLEN-1:0]  ex_op_a,
    input  logic [XLEN-1:0]  ex_op_b,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic             stall,
    input  logic             flush,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             br_taken,
    output logic             br_illegal,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    bht_cnt_t w_rd_cnt;
    logic     w_accept;
    logic     w_taken;
    logic     w_legal;
    logic     w_mispred;

    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_br_taken;
    logic            r_br_illegal;

    branch_bht #(
        .XLEN      (XLEN),
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_pc    (if_pc),
        .o_rd_cnt   (w_rd_cnt),
        .i_wr_en    (w_accept & w_legal),
        .i_wr_pc    (ex_pc),
        .i_wr_taken (w_taken)
    );

    assign if_pred_taken = w_rd_cnt[1];
    assign w_accept      = ex_valid & ex_is_branch & ~stall & ~flush;
    assign w_mispred     = w_accept & w_legal & (w_taken != ex_pred_taken);

    // Branch condition evaluation; reserved funct3 encodings resolve not-taken.
    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        case (ex_fun3)
            BEQ:     w_taken = (ex_op_a == ex_op_b);
            BNE:     w_taken = (ex_op_a != ex_op_b);
            BLT:     w_taken = ($signed(ex_op_a) <  $signed(ex_op_b));
            BGE:     w_taken = ($signed(ex_op_a) >= $signed(ex_op_b));
            BLTU:    w_taken = (ex_op_a <  ex_op_b);
            BGEU:    w_taken = (ex_op_a >= ex_op_b);
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_br_taken       <= 1'b0;
            r_br_illegal     <= 1'b0;
        end else begin
            r_redirect_valid <= w_mispred;
            r_br_illegal     <= w_accept & ~w_legal;
            if (w_accept) begin
                r_redirect_pc <= w_taken ? ex_target : ex_pc + XLEN'(4);
                r_br_taken    <= w_taken;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign br_taken       = r_br_taken;
    assign br_illegal     = r_br_illegal;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispred;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_accept && !(&r_stat_branches)) begin
                r_stat_branches <= r_stat_branches + CNT_W'(1);
            end
            if (w_mispred && !(&r_stat_mispred)) begin
                r_stat_mispred <= r_stat_mispred + CNT_W'(1);
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes expected outputs,
// monitor pops and compares one cycle after each edge.
module tb_branch_resolve_unit;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   if_pc;
    logic          if_pred_taken;
    logic          ex_valid, ex_is_branch, ex_pred_taken, stall, flush;
    logic [2:0]    ex_fun3;
    logic [31:0]   ex_op_a, ex_op_b, ex_pc, ex_target;
    logic          redirect_valid, br_taken, br_illegal;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] stat_branches, stat_mispred;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_fun3(ex_fun3),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .br_taken(br_taken), .br_illegal(br_illegal),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        bt;
        logic        bi;
        int          sb;
        int          sm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state
    int          m_bht [64];
    logic [31:0] m_rpc = '0;
    logic        m_bt  = 1'b0;
    int          m_sb  = 0;
    int          m_sm  = 0;
    bit          m_init = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] p);
        return int'((p >> 2) % 64);
    endfunction

    function automatic bit cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int signed sa = a;
        int signed sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int stat_port(input int v);
`ifdef BRANCH_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // One clock of stimulus plus model update
    task automatic step(input logic r, input logic v, input logic br, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pr, input logic st, input logic fl,
                        input logic [31:0] ipc);
        exp_t e;
        bit   acc, legal, tk;
        rst = r; ex_valid = v; ex_is_branch = br; ex_fun3 = f3; ex_op_a = a; ex_op_b = b;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pr; stall = st; flush = fl; if_pc = ipc;
        @(negedge clk);
        if (m_init) chk("if_pred_taken", 32'(if_pred_taken), 32'(m_bht[idx(ipc)] >= 2));
        e.rv = 1'b0; e.bi = 1'b0;
        if (r) begin
            for (int i = 0; i < 64; i++) m_bht[i] = 1;
            m_rpc = '0; m_bt = 1'b0; m_sb = 0; m_sm = 0; m_init = 1'b1;
        end else begin
            acc = v && br && !st && !fl;
            if (acc) begin
                legal = !(f3 == 3'd2 || f3 == 3'd3);
                tk    = cond(f3, a, b);
                m_bt  = tk;
                m_rpc = tk ? tgt : pc + 32'd4;
                e.bi  = !legal;
                e.rv  = legal && (tk != pr);
                if (m_sb < 15) m_sb++;
                if (e.rv && m_sm < 15) m_sm++;
                if (legal) begin
                    if (tk) m_bht[idx(pc)] = (m_bht[idx(pc)] < 3) ? m_bht[idx(pc)] + 1 : 3;
                    else    m_bht[idx(pc)] = (m_bht[idx(pc)] > 0) ? m_bht[idx(pc)] - 1 : 0;
                end
            end
        end
        e.rpc = m_rpc; e.bt = m_bt;
        e.sb = stat_port(m_sb); e.sm = stat_port(m_sm);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, ipc);
    endtask

    // Monitor: registered outputs compared after every edge with a pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
                chk("redirect_pc",    redirect_pc,          e.rpc);
                chk("br_taken",       32'(br_taken),        32'(e.bt));
                chk("br_illegal",     32'(br_illegal),      32'(e.bi));
                chk("stat_branches",  32'(stat_branches),   32'(e.sb));
                chk("stat_mispred",   32'(stat_mispred),    32'(e.sm));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, pc;
        step(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 3'd0, 5, 5, 32'h10, 32'h80, 0, 0, 0, 0);  // accept under rst discarded
        // 1: beq taken, mispredicted
        step(0, 1, 1, 3'd0, 5, 5, 32'h20, 32'h200, 0, 0, 0, 32'h20);
        idle(32'h20);
        // 2: signed vs unsigned compares; pc+4 redirect
        step(0, 1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h30, 32'h300, 1, 0, 0, 32'h30);
        step(0, 1, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h100, 32'h400, 1, 0, 0, 32'h100);
        step(0, 1, 1, 3'd7, 0, 1, 32'hFFFF_FFFC, 32'h8, 1, 0, 0, 32'h0);
        // 3: train pc=0x40
        repeat (4) step(0, 1, 1, 3'd5, 7, 7, 32'h40, 32'h500, 1, 0, 0, 32'h40);
        idle(32'h40);
        step(0, 1, 1, 3'd1, 7, 7, 32'h40, 32'h500, 1, 0, 0, 32'h40);
        idle(32'h40);
        step(0, 1, 1, 3'd1, 7, 7, 32'h40, 32'h500, 1, 0, 0, 32'h40);
        idle(32'h40);
        // 4: stall, flush, both
        step(0, 1, 1, 3'd0, 1, 1, 32'h40, 32'h600, 0, 1, 0, 32'h40);
        step(0, 1, 1, 3'd0, 1, 1, 32'h40, 32'h600, 0, 0, 1, 32'h40);
        step(0, 1, 1, 3'd0, 1, 1, 32'h40, 32'h600, 0, 1, 1, 32'h40);
        idle(32'h40);
        // 5: reserved funct3
        step(0, 1, 1, 3'd2, 3, 3, 32'h40, 32'h700, 1, 0, 0, 32'h40);
        step(0, 1, 1, 3'd3, 3, 3, 32'h44, 32'h700, 0, 0, 0, 32'h44);
        idle(32'h40);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000 ^ b;
            pc = {22'($urandom), 8'($urandom_range(0, 63)), 2'b00};
            step(0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) != 0),
                 3'($urandom_range(0, 7)), a, b, pc, $urandom,
                 1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 {22'd0, 8'($urandom_range(0, 63)), 2'b00});
        end
        // 6: saturating stats, then reset clears them
        step(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 3'd0, 9, 9, 32'h80, 32'h900, 0, 0, 0, 32'h80);
        idle(32'h80);
        step(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h80);
        idle(32'h80);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
